imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder: the memory end of the fetch request path. Accepts PC fetch requests
//  from the IF stage over valid/ready, reads a word-addressed instruction RAM, and returns the word after
//  a fixed pipeline latency through a small response FIFO. A flush from PC redirect drops all in-flight work.
// PARAMETERS
//  ADDR_WIDTH   64    fetch address width (byte address)
//  INST_WIDTH   32    instruction word width
//  DEPTH_WORDS  1024  RAM depth in words; power of two
//  LATENCY      2     request-accept to resp_valid cycles, >=1
//  FIFO_DEPTH   4     response FIFO entries, >= LATENCY+1
// PORTS
//  clk         in   1            clock
//  reset       in   1            active-low synchronous reset
//  req_valid   in   1            fetch request valid
//  req_ready   out  1            responder can accept request
//  req_addr    in   ADDR_WIDTH   fetch PC
//  flush       in   1            redirect; kill in-flight and queued responses
//  resp_valid  out  1            response valid
//  resp_ready  in   1            IF/decode accepts response
//  resp_addr   out  ADDR_WIDTH   PC of returned word
//  resp_inst   out  INST_WIDTH   instruction word
//  resp_err    out  1            misaligned or out-of-range fetch
//  wr_en       in   1            backdoor load write enable
//  wr_addr     in   $clog2(DEPTH_WORDS)  word index for load
//  wr_data     in   INST_WIDTH   load data
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pipeline valids, FIFO pointers, occupancy cleared; resp_valid=0,
//    resp_addr=0, resp_inst=0, resp_err=0, req_ready=0 during reset, 1 first cycle after. RAM not cleared.
//  - Accept = req_valid & req_ready & ~flush. Word index = req_addr[2+:$clog2(DEPTH_WORDS)].
//  - Credit: req_ready = ~flush & (inflight + fifo_count < FIFO_DEPTH); inflight counts pipeline stages
//    holding a valid request. Guarantees no response is ever dropped for lack of FIFO space.
//  - Accepted request reaches FIFO head exactly LATENCY cycles later if FIFO empty (resp_valid then high).
//  - Response pops on resp_valid & resp_ready; outputs held stable while resp_valid & ~resp_ready.
//  - Simultaneous push and pop on full FIFO allowed; occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - resp_err=1 if req_addr[1:0]!=0 or req_addr >= DEPTH_WORDS*4; then resp_inst = NOP (0x0000_0013).
//  - flush: same edge clears all pipeline valids and FIFO (resp_valid=0 next cycle); request in a flush
//    cycle is not accepted. Response handshake in flush cycle is discarded with the rest.
//  - wr_en to same word as a read in same cycle: read returns old data (read-before-write).
//  - Backdoor writes ignore flush and credit; always take effect.
// CONFIGURATION
//  IMEM_PARITY_EN defined: RAM stores one extra even-parity bit per word, computed on wr_data; checked at
//  read; mismatch sets resp_err=1 and forces resp_inst=NOP. Not defined: no parity bit, no check, resp_err
//  from address faults only.
// STRUCTURE
//  Package imem_pkg: INST_NOP constant, imem_resp_t struct {addr, inst, err}.
//  Sub-module imem_resp_fifo (parameterised depth/width, count output) holds imem_resp_t entries.
//  Pipeline stage regs and RAM array inline in imem_responder.
// TESTING
//  1 Load word 0x0010_0093 at index 4; req_addr=0x10, resp_ready=1 -> resp_valid at +LATENCY, inst=0x00100093, err=0.
//  2 Back-to-back 8 requests, resp_ready=0 -> req_ready drops after FIFO_DEPTH accepted; release -> 8 in-order responses, none lost.
//  3 req_addr=0x12 -> resp_err=1, resp_inst=0x00000013; req_addr=DEPTH_WORDS*4 -> resp_err=1.
//  4 Three requests in flight, flush pulse -> resp_valid=0 next cycle, no stale response ever appears; next request answered normally.
//  5 wr_en to index 4 same cycle as read of 0x10 -> old word returned; repeat read -> new word.
//  6 IMEM_PARITY_EN: backdoor-corrupt stored parity -> resp_err=1, inst=NOP; without macro same test -> err=0.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared response type and NOP encoding for the instruction-memory responder.
package imem_pkg;
    localparam int IMEM_ADDR_W = 64;
    localparam int IMEM_INST_W = 32;
    localparam logic [IMEM_INST_W-1:0] INST_NOP = 32'h0000_0013;
    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] addr;
        logic [IMEM_INST_W-1:0] inst;
        logic                   err;
    } imem_resp_t;
endpackage

// File: rtl/imem_resp_fifo.sv
// imem_resp_fifo: circular response FIFO with occupancy count and synchronous clear.
module imem_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-side instruction RAM responder with fixed latency and credit-gated response FIFO.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag mismatches as fetch errors.
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = IMEM_ADDR_W,
    parameter int INST_WIDTH  = IMEM_INST_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int IW = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic                  resp_err,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_addr,
    input  logic [INST_WIDTH-1:0] wr_data
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef IMEM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    logic [INST_WIDTH+PW-1:0] mem [DEPTH_WORDS];
    logic [INST_WIDTH+PW-1:0] rd_word;
    logic                     addr_err, par_err, fault, accept, push, pop;
    logic [CW-1:0]            count, inflight;
    logic [CW:0]              occ;
    imem_resp_t               fresh, push_data, head;

    // Asynchronous read sees the pre-edge contents, so a same-cycle write returns old data.
    assign rd_word  = mem[req_addr[2+:IW]];
    assign addr_err = (req_addr[1:0] != 2'b00) | (req_addr[ADDR_WIDTH-1:IW+2] != '0);
`ifdef IMEM_PARITY_EN
    assign par_err = ^rd_word;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {^wr_data, wr_data};
    end
`else
    assign par_err = 1'b0;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
`endif
    assign fault = addr_err | par_err;
    always_comb begin
        fresh.addr = IMEM_ADDR_W'(req_addr);
        fresh.err  = fault;
        fresh.inst = fault ? INST_NOP : IMEM_INST_W'(rd_word[INST_WIDTH-1:0]);
    end

    // Credit counts both FIFO entries and requests still in the pipeline, so a push never overflows.
    assign occ       = {1'b0, inflight} + {1'b0, count};
    assign req_ready = reset & ~flush & (occ < (CW+1)'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;

    generate
        if (LATENCY == 1) begin : g_direct
            assign push      = accept;
            assign push_data = fresh;
            assign inflight  = '0;
        end else begin : g_pipe
            logic [LATENCY-2:0] sv;
            imem_resp_t         sd [LATENCY-1];
            always_ff @(posedge clk) begin
                if (!reset || flush) begin
                    sv <= '0;
                end else begin
                    sv[0] <= accept;
                    for (int i = 1; i < LATENCY - 1; i++) sv[i] <= sv[i-1];
                end
                sd[0] <= fresh;
                for (int i = 1; i < LATENCY - 1; i++) sd[i] <= sd[i-1];
            end
            assign push      = sv[LATENCY-2];
            assign push_data = sd[LATENCY-2];
            assign inflight  = CW'($countones(sv));
        end
    endgenerate

    imem_resp_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(imem_resp_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign resp_valid = count != '0;
    assign pop        = resp_valid & resp_ready;
    assign resp_addr  = resp_valid ? ADDR_WIDTH'(head.addr) : '0;
    assign resp_inst  = resp_valid ? INST_WIDTH'(head.inst) : '0;
    assign resp_err   = resp_valid & head.err;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder (LATENCY=2, FIFO_DEPTH=4, 1024 words).
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, flush, resp_valid, resp_ready, resp_err, wr_en;
    logic [63:0] req_addr, resp_addr;
    logic [31:0] resp_inst, wr_data;
    logic [9:0]  wr_addr;
    int          n_chk = 0;
    int          n_fail = 0;

    imem_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_inst(resp_inst), .resp_err(resp_err), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        wr_en = 1'b1;
        wr_addr = idx;
        wr_data = data;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int j, r;
        reset = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0; wr_en = 1'b0;
        req_addr = '0; wr_addr = '0; wr_data = '0;
        cyc(); cyc();
        #1;
        chk("rst req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst resp_addr", resp_addr, 64'd0);
        chk("rst resp_inst", {32'd0, resp_inst}, 64'd0);
        chk("rst resp_err", {63'd0, resp_err}, 64'd0);
        reset = 1'b1;
        cyc();
        chk("post-rst req_ready", {63'd0, req_ready}, 64'd1);
        load(10'd4, 32'h0010_0093);
        for (int i = 0; i < 8; i++) load(10'(8 + i), 32'hC0DE_0000 + 32'(8 + i));

        // Test 1: single fetch, response LATENCY cycles later
        req_valid = 1'b1; req_addr = 64'h10; resp_ready = 1'b1;
        #1;
        chk("t1 req_ready", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
        #1;
        chk("t1 valid early", {63'd0, resp_valid}, 64'd0);
        cyc();
        chk("t1 valid", {63'd0, resp_valid}, 64'd1);
        chk("t1 addr", resp_addr, 64'h10);
        chk("t1 inst", {32'd0, resp_inst}, 64'h0010_0093);
        chk("t1 err", {63'd0, resp_err}, 64'd0);
        cyc();
        chk("t1 popped", {63'd0, resp_valid}, 64'd0);

        // Test 2: back-pressure; credit stops at FIFO_DEPTH
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_addr = 64'((8 + k) * 4);
            #1;
            chk("t2 ready open", {63'd0, req_ready}, 64'd1);
            cyc();
        end
        req_addr = 64'(12 * 4);
        #1;
        chk("t2 ready closed", {63'd0, req_ready}, 64'd0);
        cyc(); cyc(); cyc();
        chk("t2 still closed", {63'd0, req_ready}, 64'd0);
        chk("t2 held addr", resp_addr, 64'h20);
        chk("t2 held inst", {32'd0, resp_inst}, 64'hC0DE_0008);
        resp_ready = 1'b1;
        j = 4; r = 0;
        for (int c = 0; c < 40 && r < 8; c++) begin
            req_valid = (j < 8);
            req_addr = 64'((8 + j) * 4);
            #1;
            if (resp_valid) begin
                chk("t2 order addr", resp_addr, 64'((8 + r) * 4));
                chk("t2 order inst", {32'd0, resp_inst}, {32'd0, 32'hC0DE_0000 + 32'(8 + r)});
                r++;
            end
            if (req_valid && req_ready) j++;
            cyc();
        end
        chk("t2 responses", 64'(r), 64'd8);
        req_valid = 1'b0;
        cyc();
        chk("t2 no extra", {63'd0, resp_valid}, 64'd0);

        // Test 3: misaligned and out-of-range fetches
        req_valid = 1'b1; req_addr = 64'h12;
        cyc();
        req_addr = 64'h1000;
        cyc();
        req_valid = 1'b0;
        #1;
        chk("t3 mis addr", resp_addr, 64'h12);
        chk("t3 mis err", {63'd0, resp_err}, 64'd1);
        chk("t3 mis inst", {32'd0, resp_inst}, 64'h13);
        cyc();
        chk("t3 oor addr", resp_addr, 64'h1000);
        chk("t3 oor err", {63'd0, resp_err}, 64'd1);
        chk("t3 oor inst", {32'd0, resp_inst}, 64'h13);
        cyc();

        // Test 4: flush with three requests in flight
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_addr = 64'(32 + 4 * k);
            cyc();
        end
        flush = 1'b1; req_addr = 64'h2C;
        #1;
        chk("t4 ready in flush", {63'd0, req_ready}, 64'd0);
        cyc();
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        #1;
        chk("t4 valid after flush", {63'd0, resp_valid}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4 no stale", {63'd0, resp_valid}, 64'd0);
        end
        req_valid = 1'b1; req_addr = 64'h10;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t4 recover valid", {63'd0, resp_valid}, 64'd1);
        chk("t4 recover inst", {32'd0, resp_inst}, 64'h0010_0093);
        cyc();

        // Test 5: read-before-write on the same word
        req_valid = 1'b1; req_addr = 64'h10;
        wr_en = 1'b1; wr_addr = 10'd4; wr_data = 32'h0020_0113;
        cyc();
        req_valid = 1'b0; wr_en = 1'b0;
        cyc();
        chk("t5 old word", {32'd0, resp_inst}, 64'h0010_0093);
        cyc();
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t5 new word", {32'd0, resp_inst}, 64'h0020_0113);
        cyc();

        // Test 6: stored parity corruption
`ifdef IMEM_PARITY_EN
        dut.mem[4][32] = ~dut.mem[4][32];
`endif
        req_valid = 1'b1; req_addr = 64'h10;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t6 valid", {63'd0, resp_valid}, 64'd1);
`ifdef IMEM_PARITY_EN
        chk("t6 parity err", {63'd0, resp_err}, 64'd1);
        chk("t6 parity inst", {32'd0, resp_inst}, 64'h13);
`else
        chk("t6 no parity err", {63'd0, resp_err}, 64'd0);
        chk("t6 inst", {32'd0, resp_inst}, 64'h0020_0113);
`endif
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
